// File: rtl/softmax_job_sched.sv
// Round-robin job scheduler that sequences requesters onto one softmax core.
// Optional watchdog abort: define SOFTMAX_SCHED_TIMEOUT_EN.
module softmax_job_sched #(
    parameter int NREQ           = 2,
    parameter int ADDRSIZE       = 4,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int IDW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDRSIZE-1:0] req_start_addr,
    input  logic [NREQ*ADDRSIZE-1:0] req_end_addr,
    output logic                     sm_init,
    output logic                     sm_start,
    output logic [ADDRSIZE-1:0]      sm_start_addr,
    output logic [ADDRSIZE-1:0]      sm_end_addr,
    input  logic                     sm_done,
    output logic                     sm_reset,
    output logic                     cpl_valid,
    output logic [IDW-1:0]           cpl_id,
    output logic                     cpl_error,
    output logic                     busy
);

    typedef enum logic [2:0] {IDLE, INIT, START, WAIT_DONE, DRAIN, CPL} state_t;

    state_t              r_state, w_next;
    logic [IDW-1:0]      r_rr, r_id, w_gid, w_rr_next;
    logic [ADDRSIZE-1:0] r_sa, r_ea, w_sa, w_ea;
    logic [NREQ-1:0]     w_gnt;
    logic                w_found, w_bad, w_accept, w_timeout, r_err;

    // Round-robin search beginning at r_rr; first valid requester wins.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_gnt   = '0;
        w_gid   = '0;
        w_sa    = '0;
        w_ea    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_found && req_valid[idx]) begin
                w_found    = 1'b1;
                w_gnt[idx] = 1'b1;
                w_gid      = IDW'(idx);
                w_sa       = req_start_addr[idx*ADDRSIZE +: ADDRSIZE];
                w_ea       = req_end_addr[idx*ADDRSIZE +: ADDRSIZE];
            end
        end
    end

    assign w_bad     = (w_ea <= w_sa);
    assign w_accept  = (r_state == IDLE) && w_found && !reset;
    assign w_rr_next = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + IDW'(1);

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_sm_reset;

    // Counter reaches TIMEOUT_CYCLES on the same edge that enters CPL.
    assign w_timeout = ((r_state == WAIT_DONE) || (r_state == DRAIN)) &&
                       (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_sm_reset <= 1'b0;
        end else begin
            r_sm_reset <= w_timeout;
            if (r_state == START)
                r_cnt <= '0;
            else if ((r_state == WAIT_DONE) || (r_state == DRAIN))
                r_cnt <= r_cnt + CW'(1);
        end
    end

    assign sm_reset = r_sm_reset;
`else
    assign w_timeout = 1'b0;
    assign sm_reset  = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_found) w_next = w_bad ? CPL : INIT;
            INIT:      w_next = START;
            START:     w_next = WAIT_DONE;
            WAIT_DONE: if (w_timeout) w_next = CPL;
                       else if (sm_done) w_next = DRAIN;
            DRAIN:     if (w_timeout || !sm_done) w_next = CPL;
            CPL:       w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_rr    <= '0;
            r_id    <= '0;
            r_sa    <= '0;
            r_ea    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_rr  <= w_rr_next;
                r_id  <= w_gid;
                r_sa  <= w_sa;
                r_ea  <= w_ea;
                r_err <= w_bad;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign req_ready     = w_accept ? w_gnt : '0;
    assign sm_init       = (r_state == INIT);
    assign sm_start      = (r_state == START);
    assign sm_start_addr = r_sa;
    assign sm_end_addr   = r_ea;
    assign cpl_valid     = (r_state == CPL);
    assign cpl_id        = r_id;
    assign cpl_error     = (r_state == CPL) && r_err;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_softmax_job_sched.sv
// Directed self-checking bench for softmax_job_sched (NREQ=2, ADDRSIZE=4).
module tb_softmax_job_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid, req_ready;
    logic [7:0] req_start_addr, req_end_addr;
    logic       sm_init, sm_start, sm_done, sm_reset;
    logic [3:0] sm_start_addr, sm_end_addr;
    logic       cpl_valid, cpl_error, busy;
    logic [0:0] cpl_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    softmax_job_sched #(.NREQ(2), .ADDRSIZE(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_start_addr(req_start_addr), .req_end_addr(req_end_addr),
        .sm_init(sm_init), .sm_start(sm_start),
        .sm_start_addr(sm_start_addr), .sm_end_addr(sm_end_addr),
        .sm_done(sm_done), .sm_reset(sm_reset),
        .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_error(cpl_error),
        .busy(busy)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 2'b11; sm_done = 1'b1;
        req_start_addr = 8'h21; req_end_addr = 8'h93;
        step(); step(); #1;
        checks++;
        if ({req_ready, sm_init, sm_start, sm_start_addr, sm_end_addr, sm_reset,
             cpl_valid, cpl_id, cpl_error, busy} !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h %b %b %h %h %b %b %h %b %b want all 0",
                     req_ready, sm_init, sm_start, sm_start_addr, sm_end_addr, sm_reset,
                     cpl_valid, cpl_id, cpl_error, busy);
        end
        reset = 1'b0; req_valid = 2'b00; sm_done = 1'b0;
        step();
    endtask

    task automatic test_single();
        req_valid = 2'b01; req_start_addr = 8'h00; req_end_addr = 8'h08; #1;
        checks++;
        if ({req_ready, busy} !== 3'b010) begin
            errors++; $display("FAIL single_accept: got %b want 010", {req_ready, busy});
        end
        step(); req_valid = 2'b00; #1;
        checks++;
        if ({sm_init, sm_start, busy, sm_start_addr, sm_end_addr} !== {3'b101, 4'd0, 4'd8}) begin
            errors++; $display("FAIL single_init: got %b %h %h", {sm_init, sm_start, busy},
                               sm_start_addr, sm_end_addr);
        end
        step(); #1;
        checks++;
        if ({sm_init, sm_start} !== 2'b01) begin
            errors++; $display("FAIL single_start: got %b want 01", {sm_init, sm_start});
        end
        step(); sm_done = 1'b1; #1;
        checks++;
        if ({sm_init, sm_start, cpl_valid, busy} !== 4'b0001) begin
            errors++; $display("FAIL single_wait: got %b want 0001", {sm_init, sm_start, cpl_valid, busy});
        end
        for (int i = 0; i < 7; i++) begin
            step(); #1;
            checks++;
            if ({cpl_valid, busy} !== 2'b01) begin
                errors++; $display("FAIL single_drain%0d: got %b want 01", i, {cpl_valid, busy});
            end
        end
        step(); sm_done = 1'b0; #1;
        checks++;
        if (cpl_valid !== 1'b0) begin
            errors++; $display("FAIL single_fall: cpl_valid got %b want 0", cpl_valid);
        end
        step(); #1;
        checks++;
        if ({cpl_valid, cpl_id, cpl_error} !== 3'b100) begin
            errors++; $display("FAIL single_cpl: got %b want 100", {cpl_valid, cpl_id, cpl_error});
        end
        step(); #1;
        checks++;
        if ({busy, cpl_valid} !== 2'b00) begin
            errors++; $display("FAIL single_idle: got %b want 00", {busy, cpl_valid});
        end
        step();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        reset = 1'b1; step(); reset = 1'b0;
        req_valid = 2'b11; req_start_addr = 8'h21; req_end_addr = 8'h63; #1;
        if (req_ready != 2'b00) pulses++;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL b2b_grant0: got %b want 01", req_ready);
        end
        // done held high through INIT/START must not disturb sequencing
        step(); sm_done = 1'b1; #1;
        if (req_ready != 2'b00) pulses++;
        checks++;
        if ({sm_init, sm_start_addr, sm_end_addr} !== {1'b1, 4'd1, 4'd3}) begin
            errors++; $display("FAIL b2b_init0: got %b %h %h", sm_init, sm_start_addr, sm_end_addr);
        end
        step(); #1;
        if (req_ready != 2'b00) pulses++;
        checks++;
        if ({sm_init, sm_start, busy} !== 3'b011) begin
            errors++; $display("FAIL b2b_start0: got %b want 011", {sm_init, sm_start, busy});
        end
        step(); #1;
        if (req_ready != 2'b00) pulses++;
        step(); sm_done = 1'b0; #1;
        if (req_ready != 2'b00) pulses++;
        step(); #1;
        if (req_ready != 2'b00) pulses++;
        checks++;
        if ({cpl_valid, cpl_id, cpl_error, req_ready} !== 5'b10000) begin
            errors++; $display("FAIL b2b_cpl0: got %b want 10000", {cpl_valid, cpl_id, cpl_error, req_ready});
        end
        step(); #1;
        if (req_ready != 2'b00) pulses++;
        checks++;
        if ({req_ready, sm_start_addr} !== {2'b10, 4'd1}) begin
            errors++; $display("FAIL b2b_grant1: got %b %h want 10 1", req_ready, sm_start_addr);
        end
        step(); #1;
        if (req_ready != 2'b00) pulses++;
        checks++;
        if ({sm_init, sm_start_addr, sm_end_addr} !== {1'b1, 4'd2, 4'd6}) begin
            errors++; $display("FAIL b2b_init1: got %b %h %h", sm_init, sm_start_addr, sm_end_addr);
        end
        step(); #1;
        if (req_ready != 2'b00) pulses++;
        step(); sm_done = 1'b1; #1;
        if (req_ready != 2'b00) pulses++;
        step(); sm_done = 1'b0; #1;
        if (req_ready != 2'b00) pulses++;
        step(); req_valid = 2'b00; #1;
        checks++;
        if ({cpl_valid, cpl_id, cpl_error} !== 3'b110) begin
            errors++; $display("FAIL b2b_cpl1: got %b want 110", {cpl_valid, cpl_id, cpl_error});
        end
        checks++;
        if (pulses !== 2) begin
            errors++; $display("FAIL b2b_ready_pulses: got %0d want 2", pulses);
        end
        step();
    endtask

    task automatic test_bad_range();
        req_valid = 2'b10; req_start_addr = 8'h50; req_end_addr = 8'h50; #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL bad_grant: got %b want 10", req_ready);
        end
        step(); req_valid = 2'b00; #1;
        checks++;
        if ({cpl_valid, cpl_id, cpl_error, sm_init, sm_start, sm_start_addr, sm_end_addr}
                !== {5'b11100, 4'd5, 4'd5}) begin
            errors++; $display("FAIL bad_cpl: got %b %b %b %b %b %h %h", cpl_valid, cpl_id,
                               cpl_error, sm_init, sm_start, sm_start_addr, sm_end_addr);
        end
        step(); #1;
        checks++;
        if ({busy, sm_init, sm_start, cpl_valid} !== 4'b0000) begin
            errors++; $display("FAIL bad_idle: got %b want 0000", {busy, sm_init, sm_start, cpl_valid});
        end
        step();
    endtask

    task automatic test_reset_mid_job();
        req_valid = 2'b01; req_start_addr = 8'h03; req_end_addr = 8'h09; #1;
        step(); req_valid = 2'b00;
        step(); step(); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_busy: got %b want 1", busy);
        end
        reset = 1'b1; step(); reset = 1'b0; #1;
        checks++;
        if ({req_ready, sm_init, sm_start, sm_start_addr, sm_end_addr, sm_reset,
             cpl_valid, cpl_id, cpl_error, busy} !== 17'h0) begin
            errors++; $display("FAIL rst_mid_outputs: got busy=%b sa=%h ea=%h cpl=%b want all 0",
                               busy, sm_start_addr, sm_end_addr, cpl_valid);
        end
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            checks++;
            if ({cpl_valid, busy} !== 2'b00) begin
                errors++; $display("FAIL rst_mid_quiet%0d: got %b want 00", i, {cpl_valid, busy});
            end
        end
        req_valid = 2'b11; #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL rst_mid_regrant: got %b want 01", req_ready);
        end
        step(); req_valid = 2'b00;
        reset = 1'b1; step(); reset = 1'b0;
        step();
    endtask

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        bit hit = 0;
        sm_done = 1'b0;
        req_valid = 2'b01; req_start_addr = 8'h00; req_end_addr = 8'h04; #1;
        step(); req_valid = 2'b00;
        step(); step();
        while (!hit && n < 100) begin
            #1;
            if (sm_reset === 1'b1) hit = 1;
            else begin n++; step(); end
        end
        checks++;
        if (!hit || n !== 16) begin
            errors++; $display("FAIL timeout_cycles: got hit=%0d n=%0d want hit=1 n=16", hit, n);
        end
        checks++;
        if ({cpl_valid, cpl_error} !== 2'b11) begin
            errors++; $display("FAIL timeout_cpl: got %b want 11", {cpl_valid, cpl_error});
        end
        step(); #1;
        checks++;
        if ({sm_reset, busy} !== 2'b00) begin
            errors++; $display("FAIL timeout_after: got %b want 00", {sm_reset, busy});
        end
        step();
    endtask
`else
    task automatic test_no_timeout();
        int ok = 0;
        sm_done = 1'b0;
        req_valid = 2'b01; req_start_addr = 8'h00; req_end_addr = 8'h04; #1;
        step(); req_valid = 2'b00;
        step(); step();
        for (int i = 0; i < 1000; i++) begin
            #1;
            if ({busy, sm_reset, cpl_valid} === 3'b100) ok++;
            step();
        end
        checks++;
        if (ok !== 1000) begin
            errors++; $display("FAIL no_timeout_wait: got %0d good cycles want 1000", ok);
        end
        reset = 1'b1; step(); reset = 1'b0;
        step();
    endtask
`endif

    initial begin
        reset = 1'b1; req_valid = 2'b00; sm_done = 1'b0;
        req_start_addr = 8'h00; req_end_addr = 8'h00;
        step();
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_range();
        test_reset_mid_job();
`ifdef SOFTMAX_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/softmax_job_sched.md
SOFTMAX_JOB_SCHED -- requirements
Module: softmax_job_sched

Interface
REQ-001 SHALL have parameter NREQ, default 2, meaning number of requesters sharing one softmax core.
REQ-002 SHALL have parameter ADDRSIZE, default 4, meaning on-chip memory address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning watchdog limit in cycles.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester job request.
REQ-007 SHALL have port req_ready  output  NREQ  per-requester accept strobe.
REQ-008 SHALL have port req_start_addr  input  NREQ*ADDRSIZE  per-requester first data address.
REQ-009 SHALL have port req_end_addr  input  NREQ*ADDRSIZE  per-requester end address.
REQ-010 SHALL have port sm_init  output  1  core address-latch pulse.
REQ-011 SHALL have port sm_start  output  1  core start pulse.
REQ-012 SHALL have port sm_start_addr  output  ADDRSIZE  core start_addr.
REQ-013 SHALL have port sm_end_addr  output  ADDRSIZE  core end_addr.
REQ-014 SHALL have port sm_done  input  1  core done; high for the whole output stream.
REQ-015 SHALL have port sm_reset  output  1  core abort pulse.
REQ-016 SHALL have port cpl_valid  output  1  job-completion pulse.
REQ-017 SHALL have port cpl_id  output  max(1,ceil(log2 NREQ))  requester index of the completed job.
REQ-018 SHALL have port cpl_error  output  1  completion qualifier: bad range or timeout.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, INIT, START, WAIT_DONE, DRAIN, CPL.
REQ-021 IDLE: when any req_valid is high, SHALL grant round-robin starting at pointer rr. In the same cycle it SHALL pulse req_ready[g], latch addresses and g, and set rr to g+1 mod NREQ.
REQ-022 Requesters SHALL hold req_valid and addresses until req_ready; req_ready SHALL be high only in IDLE and only for one bit.
REQ-023 If the latched end_addr <= start_addr, the FSM SHALL go to CPL with error set and SHALL NOT pulse sm_init or sm_start.
REQ-024 Otherwise the FSM SHALL go IDLE->INIT->START->WAIT_DONE.
REQ-025 sm_init SHALL be high only in INIT; sm_start SHALL be high only in START, so both fall at accept+1 and accept+2.
REQ-026 sm_start_addr and sm_end_addr SHALL hold the latched job addresses from accept until the next accept.
REQ-027 WAIT_DONE SHALL move to DRAIN on sm_done=1; DRAIN SHALL move to CPL on sm_done=0 (falling edge).
REQ-028 CPL SHALL last one cycle, assert cpl_valid with cpl_id and cpl_error, then return to IDLE.
REQ-029 A new job SHALL NOT be accepted in CPL, so there is at least one IDLE cycle between jobs.
REQ-030 sm_done high while in IDLE, INIT or START SHALL be ignored.

Reset
REQ-031 On reset the FSM SHALL go to IDLE and rr SHALL be cleared to 0.
REQ-032 On reset every output SHALL be 0, including sm_start_addr, sm_end_addr and sm_reset.
REQ-033 Reset SHALL take priority over every other event.
REQ-034 Reset mid-job SHALL discard the job with no cpl_valid.

Configuration
REQ-035 The feature SHALL be selected by macro SOFTMAX_SCHED_TIMEOUT_EN.
REQ-036 With the macro defined, a cycle counter SHALL clear on entry to WAIT_DONE and count in WAIT_DONE and DRAIN.
REQ-037 With the macro defined, when the counter reaches TIMEOUT_CYCLES the FSM SHALL pulse sm_reset for one cycle and go to CPL with cpl_error=1.
REQ-038 Without the macro, sm_reset SHALL be tied 0, no counter SHALL exist, and WAIT_DONE/DRAIN SHALL wait indefinitely.

Verification
REQ-039 Single job, req0 start=0 end=8, core done high 8 cycles -> sm_init at accept+1, sm_start at accept+2, cpl_valid one cycle after done falls, cpl_id=0, cpl_error=0.
REQ-040 req_valid=2'b11 held for two jobs from rr=0 -> grants req0 then req1, with one req_ready pulse each and cpl_id 0 then 1.
REQ-041 req1 start=5 end=5 -> no sm_init or sm_start, cpl_valid at accept+1, cpl_id=1, cpl_error=1.
REQ-042 Reset asserted in WAIT_DONE -> next cycle busy=0 and all outputs 0, no cpl_valid, next grant from req0.
REQ-043 With SOFTMAX_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16 and sm_done never high -> sm_reset pulse after 16 WAIT_DONE cycles, then cpl_error=1.
REQ-044 Without the macro, same stimulus -> stays in WAIT_DONE for 1000 cycles with sm_reset=0.
